// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder with a start/done handshake.
//            It resolves one bit per clock, LSB first.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RES_W = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [RES_W-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_r_next;
    logic [RES_W-1:0] w_res_next;

    assign w_s          = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_carry_next = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));

    // The result register keeps only the upper WIDTH-1 bits; the lowest bit
    // would be shifted out unused on the completion edge.
    generate
        if (WIDTH == 1) begin : g_single_bit
            assign w_r_next   = w_s;
            assign w_res_next = r_res;
        end else begin : g_multi_bit
            assign w_r_next   = {w_s, r_res};
            assign w_res_next = w_r_next[WIDTH-1:1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_carry_next;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST_BIT) begin
                        sum     <= w_r_next;
                        cout    <= w_carry_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    // A start presented during the done cycle chains straight into RUN.
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks;
    int n_fail;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Caller has already driven start with operands at the current negedge.
    task automatic run_op(input logic [7:0] exp_sum, input logic exp_cout,
                          input logic [7:0] hold_sum, input bit inject,
                          input bit chain, input logic [7:0] na, input logic [7:0] nb);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_e0", {31'd0, busy}, 32'd1);
        check("done_after_e0", {31'd0, done}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            if (inject && i == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end
            @(negedge clk);
            start = 1'b0;
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            check("sum_hold_run", {24'd0, sum}, {24'd0, hold_sum});
        end
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("sum_result", {24'd0, sum}, {24'd0, exp_sum});
        check("cout_result", {31'd0, cout}, {31'd0, exp_cout});
        if (chain) begin
            start = 1'b1;
            a     = na;
            b     = nb;
            cin   = 1'b0;
        end else begin
            @(negedge clk);
            check("done_single", {31'd0, done}, 32'd0);
            check("busy_idle", {31'd0, busy}, 32'd0);
            check("sum_after", {24'd0, sum}, {24'd0, exp_sum});
        end
    endtask

    task automatic drive_start(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vc;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        start1   = 1'b0;
        a1       = '0;
        b1       = '0;
        cin1     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        drive_start(8'h5A, 8'h3C, 1'b0);
        run_op(8'h96, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_start(8'hFF, 8'h01, 1'b0);
        run_op(8'h00, 1'b1, 8'h96, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_start(8'hFF, 8'hFF, 1'b1);
        run_op(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_start(8'h10, 8'h20, 1'b0);
        run_op(8'h30, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00);

        // Abort mid-run: outputs clear asynchronously, no done follows.
        drive_start(8'h80, 8'h80, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
            check("abort_sum_hold", {24'd0, sum}, 32'd0);
        end

        drive_start(8'h01, 8'h02, 1'b0);
        run_op(8'h03, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7F, 8'h01);
        run_op(8'h80, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00);

        start1 = 1'b1;
        a1     = 1'b1;
        b1     = 1'b1;
        cin1   = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", {31'd0, busy1}, 32'd1);
        check("w1_done_early", {31'd0, done1}, 32'd0);
        @(negedge clk);
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_busy_done", {31'd0, busy1}, 32'd0);
        check("w1_sum", {31'd0, sum1}, 32'd1);
        check("w1_cout", {31'd0, cout1}, 32'd1);
        @(negedge clk);
        check("w1_done_single", {31'd0, done1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
